// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, FSM encoding, latency defaults.
// Also holds the latched-request record and a small one-hot helper.
package alu_pkg;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_SUB     = 2'b01;
   localparam logic [1:0] OP_MULT    = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   localparam int unsigned MULT_CYCLES_DEFAULT   = 17;
   localparam int unsigned ADDSUB_CYCLES_DEFAULT = 1;

   typedef struct packed {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        owner;
   } req_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant from valid and the last owner.
// The parent keeps i_last and updates it on each accepted request.
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   output logic [1:0] o_grant,
   output logic       o_winner
);

   always_comb begin
      o_grant = '0;
      unique case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         // Contention: the requester that did not win last time goes first.
         2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
         default: o_grant = '0;
      endcase
   end

   assign o_winner = o_grant[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with round-robin arbitration,
// holds the ALU inputs for the operation latency and returns the captured result.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES   = MULT_CYCLES_DEFAULT,
   parameter int unsigned ADDSUB_CYCLES = ADDSUB_CYCLES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic [15:0] alu_operand_1,
   output logic [15:0] alu_operand_2,
   output logic [1:0]  alu_op_select,
   output logic        alu_enable,
   input  logic [15:0] alu_result
);

   localparam int unsigned CW = $clog2(MULT_CYCLES);
   localparam logic [CW-1:0] MULT_LOAD   = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] ADDSUB_LOAD = CW'(ADDSUB_CYCLES - 1);

   logic [1:0]    r_state;
   logic          r_last;
   req_t          r_req;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_rsp_data;
   logic          r_err;

   logic [1:0]    w_arb_valid;
   logic [1:0]    w_grant;
   logic          w_owner;
   logic          w_hs;
   logic [1:0]    w_op;
   logic [15:0]   w_a;
   logic [15:0]   w_b;
   logic          w_drive;

   // Arbitration is only offered in IDLE and never while reset is asserted.
   assign w_arb_valid = (!reset && r_state == ST_IDLE) ? req_valid : 2'b00;

   rr_arb2 u_arb (
      .i_valid  (w_arb_valid),
      .i_last   (r_last),
      .o_grant  (w_grant),
      .o_winner (w_owner)
   );

   assign req_ready = w_grant;
   assign w_hs      = |w_grant;
   assign w_op      = w_owner ? req_op[3:2]  : req_op[1:0];
   assign w_a       = w_owner ? req_a[31:16] : req_a[15:0];
   assign w_b       = w_owner ? req_b[31:16] : req_b[15:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_last     <= 1'b1;
         r_req      <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_err      <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_req  <= '{op: w_op, a: w_a, b: w_b, owner: w_owner};
                  r_last <= w_owner;
                  if (w_op == OP_ILLEGAL) begin
                     r_err      <= 1'b1;
                     r_rsp_data <= '0;
                     r_state    <= ST_RESP;
                  end else begin
                     r_err   <= 1'b0;
                     r_cnt   <= (w_op == OP_MULT) ? MULT_LOAD : ADDSUB_LOAD;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (r_cnt == '0) begin
                  r_state <= ST_CAPTURE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               r_rsp_data <= alu_result;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_drive       = (r_state == ST_RUN) || (r_state == ST_CAPTURE);
   assign alu_operand_1 = w_drive ? r_req.a  : '0;
   assign alu_operand_2 = w_drive ? r_req.b  : '0;
   assign alu_op_select = w_drive ? r_req.op : OP_ADD;
   assign alu_enable    = (r_state == ST_CAPTURE);

   assign rsp_valid = (r_state == ST_RESP) ? onehot2(r_req.owner) : 2'b00;
   assign rsp_err   = (r_state == ST_RESP) && r_err;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a cycle-timed behavioural model checks every output each cycle,
// while directed requests pin the model with hand-computed results, then random traffic runs.
module tb_alu_arbiter;

   localparam int MULT_C   = 17;
   localparam int ADDSUB_C = 1;

   logic        clock;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [15:0] alu_operand_1;
   logic [15:0] alu_operand_2;
   logic [1:0]  alu_op_select;
   logic        alu_enable;
   logic [15:0] alu_result;

   int n_pass  = 0;
   int n_total = 0;

   alu_arbiter #(.MULT_CYCLES(MULT_C), .ADDSUB_CYCLES(ADDSUB_C)) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .alu_operand_1 (alu_operand_1),
      .alu_operand_2 (alu_operand_2),
      .alu_op_select (alu_op_select),
      .alu_enable    (alu_enable),
      .alu_result    (alu_result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] alu_f(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = a * b;
      case (sel)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return p[15:0];
         default: return 16'h0000;
      endcase
   endfunction

   // External ALU stand-in; garbage outside the enable cycle exposes mistimed capture.
   assign alu_result = alu_enable ? alu_f(alu_op_select, alu_operand_1, alu_operand_2) : 16'hA5A5;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endfunction

   // Behavioural model: time since handshake decides every output.
   bit          m_busy = 0;
   logic        m_last = 1'b1;
   int          m_k, m_lat;
   logic [1:0]  m_op;
   logic [15:0] m_a, m_b, m_res;
   logic        m_own;
   logic [1:0]  e_ready, e_rv, e_sel;
   logic [15:0] e_o1, e_o2;
   logic        e_en, e_err;

   always @(negedge clock) begin
      e_ready = 2'b00; e_rv = 2'b00; e_sel = 2'b00;
      e_o1 = 16'h0; e_o2 = 16'h0; e_en = 1'b0; e_err = 1'b0;
      if (!m_busy) begin
         if (!reset) begin
            if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
            else                    e_ready = req_valid;
         end
      end else if (m_k == m_lat) begin
         e_rv  = m_own ? 2'b10 : 2'b01;
         e_err = (m_op == 2'b11);
      end else begin
         e_o1 = m_a; e_o2 = m_b; e_sel = m_op; e_en = (m_k == m_lat - 1);
      end

      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_err);
      chk("alu_operand_1", alu_operand_1, e_o1);
      chk("alu_operand_2", alu_operand_2, e_o2);
      chk("alu_op_select", alu_op_select, e_sel);
      chk("alu_enable", alu_enable, e_en);
      if (e_rv != 2'b00) chk("rsp_data", rsp_data, m_res);

      if (reset) begin
         m_busy = 0;
         m_last = 1'b1;
      end else if (!m_busy) begin
         if (e_ready != 2'b00) begin
            m_busy = 1;
            m_own  = e_ready[1];
            m_last = m_own;
            m_op   = m_own ? req_op[3:2]  : req_op[1:0];
            m_a    = m_own ? req_a[31:16] : req_a[15:0];
            m_b    = m_own ? req_b[31:16] : req_b[15:0];
            m_k    = 1;
            if (m_op == 2'b11)      begin m_lat = 1;             m_res = 16'h0; end
            else if (m_op == 2'b10) begin m_lat = MULT_C + 2;    m_res = 16'((32'(m_a) * 32'(m_b)) & 32'hFFFF); end
            else if (m_op == 2'b01) begin m_lat = ADDSUB_C + 2;  m_res = m_a - m_b; end
            else                    begin m_lat = ADDSUB_C + 2;  m_res = m_a + m_b; end
         end
      end else if (m_k == m_lat) begin
         m_busy = 0;
      end else begin
         m_k++;
      end
   end

   task automatic hs(input int r, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
      int n;
      @(posedge clock); #1;
      req_valid    = 2'b00;
      req_valid[r] = 1'b1;
      req_op[2*r +: 2]  = op;
      req_a[16*r +: 16] = a;
      req_b[16*r +: 16] = b;
      n = 0;
      @(negedge clock);
      while (!req_ready[r] && n < 50) begin @(negedge clock); n++; end
      ok = req_ready[r];
      if (!ok) chk("handshake_timeout", 32'(n), 32'd0);
      @(posedge clock); #1;
      req_valid = 2'b00;
      req_a = $urandom;
      req_b = $urandom;
      req_op = 4'(($urandom));
   endtask

   task automatic do_req(input int r, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic ee, input int el, input string nm);
      int n;
      bit ok;
      hs(r, op, a, b, ok);
      if (!ok) return;
      n = 1;
      @(negedge clock);
      while (rsp_valid == 2'b00 && n < 40) begin @(negedge clock); n++; end
      chk({nm, "_latency"}, 32'(n), 32'(el));
      chk({nm, "_rsp_valid"}, rsp_valid, (r == 1) ? 2'b10 : 2'b01);
      chk({nm, "_rsp_data"}, rsp_data, ed);
      chk({nm, "_rsp_err"}, rsp_err, ee);
   endtask

   initial begin
      int g, n;
      bit ok;
      reset = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Both requesters continuously valid with adds: grants alternate from requester 0.
      req_op = 4'b0000; req_a = {16'd10, 16'd1}; req_b = {16'd20, 16'd2};
      req_valid = 2'b11;
      g = 0; n = 0;
      while (g < 6 && n < 200) begin
         @(negedge clock); n++;
         if (req_ready != 2'b00) begin
            chk("grant_order", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
            g++;
         end
      end
      if (g < 6) chk("grant_timeout", 32'(g), 32'd6);
      @(posedge clock); #1 req_valid = 2'b00;
      repeat (6) @(posedge clock);

      do_req(0, 2'b00, 16'h0003, 16'h0004, 16'h0007, 1'b0, 3,  "add");
      do_req(1, 2'b01, 16'h0005, 16'h0009, 16'hFFFC, 1'b0, 3,  "sub");
      do_req(0, 2'b10, 16'hFFFD, 16'h0004, 16'hFFF4, 1'b0, 19, "mult");
      do_req(1, 2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1,  "illegal");

      // Reset during cycle 8 of a multiply aborts it.
      hs(0, 2'b10, 16'h0102, 16'h0304, ok);
      repeat (7) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      chk("abort_operand_1", alu_operand_1, 16'h0);
      chk("abort_op_select", alu_op_select, 2'b00);
      chk("abort_rsp_valid", rsp_valid, 2'b00);
      repeat (25) @(posedge clock);
      do_req(1, 2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3, "post_reset_add");

      // Random traffic: valids drop and reappear, operands churn every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         reset     = ($urandom_range(0, 299) == 0);
         req_valid = 2'($urandom_range(0, 3));
         for (int i = 0; i < 2; i++) begin
            int s;
            s = $urandom_range(0, 7);
            req_op[2*i +: 2] = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
         end
         req_a = $urandom;
         req_b = $urandom;
      end
      @(posedge clock); #1;
      reset = 1'b0; req_valid = 2'b00;
      repeat (25) @(posedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 16-bit ALU (add, subtract, 16-step Booth multiply) between two requesters. Each requester issues an operation through a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand and opcode inputs, and holds them for the operation's latency. It then captures the ALU result and returns it to the winning requester through a one-cycle response strobe. It sits between the datapath sequencers and the shared ALU instance, and is the only driver of that ALU's inputs.

## Interface
- MULT_CYCLES, 17: cycles operands are held for a multiply (16 Booth iterations plus load).
- ADDSUB_CYCLES, 1: cycles operands are held for add/subtract.
- clock  in  1  Single clock for all logic.
- reset  in  1  Synchronous, active-high.
- req_valid  in  2  Per-requester request valid; bit i = requester i.
- req_ready  out  2  Per-requester accept; one-hot or zero.
- req_op  in  2x2  Per-requester opcode: 00 add, 01 sub, 10 mult; 11 is illegal.
- req_a, req_b  in  2x16  Per-requester operands.
- rsp_valid  out  2  One-cycle result strobe to the owning requester.
- rsp_data  out  16  Result; valid only while rsp_valid is nonzero.
- rsp_err  out  1  High with rsp_valid when an illegal opcode was accepted.
- alu_operand_1, alu_operand_2  out  16  To the ALU.
- alu_op_select  out  2  To the ALU.
- alu_enable  out  1  ALU result gate.
- alu_result  in  16  From the ALU.

## Operation
- FSM states: IDLE, RUN, CAPTURE, RESP.
- IDLE:
  - Arbitrates among asserted req_valid.
  - Round-robin pointer `last` (1 bit) gives priority to the requester other than `last`.
  - If only one requester is valid, that requester wins.
  - req_ready is high combinationally, for one cycle, for the winner only.
  - The handshake completes when req_valid[i] and req_ready[i] are both high.
  - On handshake, the block latches op, a, b and owner, and sets last = owner.
  - An illegal opcode (11) goes straight to RESP with rsp_err=1 and rsp_data=0. The ALU is not driven.
  - Otherwise the FSM loads a cycle counter with (MULT_CYCLES-1) or (ADDSUB_CYCLES-1) and goes to RUN.
- RUN:
  - alu_operand_1/2 and alu_op_select are held at the latched values; alu_enable=0.
  - The counter decrements each cycle. At 0 the FSM moves to CAPTURE.
- CAPTURE:
  - Same ALU drive with alu_enable=1 for exactly one cycle.
  - alu_result is registered into rsp_data at the end of the cycle.
- RESP:
  - rsp_valid[owner]=1 for one cycle; rsp_data holds the captured value.
  - The FSM returns to IDLE.
- No new request is accepted outside IDLE. req_ready is 0 in RUN, CAPTURE and RESP.
- Outside RUN and CAPTURE, alu_operand_1/2 = 0 and alu_op_select = 00.
- The counter width is $clog2(MULT_CYCLES). Arithmetic is the ALU's; the block does not modify results.

## Timing
- Reset values:
  - state = IDLE, last = 1 (requester 0 wins first).
  - req_ready = 0 while reset is high; rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - alu_operand_1/2 = 0, alu_op_select = 00, alu_enable = 0.
- Reset asserted mid-operation aborts it. No response is produced, and the ALU inputs return to zero on the next edge.
- Latency from handshake cycle H to rsp_valid:
  - add/sub: H+3 (RUN at H+1, CAPTURE at H+2, RESP at H+3).
  - mult: H+MULT_CYCLES+2 = H+19.
  - illegal opcode: H+1.
- Back-to-back throughput: the next handshake can occur at RESP+1.
- When both requesters are continuously valid, grants strictly alternate 0,1,0,1.
- A requester that drops req_valid before the handshake loses nothing. Its pending state is not recorded.
- Requester operands may change after the handshake. The block uses the latched copies only.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MULT=2'b10, OP_ILLEGAL=2'b11.
  - FSM state encoding.
  - MULT_CYCLES and ADDSUB_CYCLES defaults.
- One sub-module, rr_arb2: a two-input round-robin arbiter. It is combinational grant from valid and last, with last updated by the parent.
- The ALU is instantiated outside this block.

## Test plan
- Requester 0 requests add 0x0003 + 0x0004 at cycle H -> rsp_valid=01 at H+3, rsp_data=0x0007, alu_enable high only at H+2.
- Requester 1 requests sub 0x0005 - 0x0009 -> rsp_valid=10, rsp_data=0xFFFC at handshake+3.
- Requester 0 requests mult 0xFFFD x 0x0004 -> operands held 17 cycles, rsp_data=0xFFF4 at handshake+19, req_ready=00 throughout.
- Both requesters hold req_valid with add ops after reset -> grants go to 0,1,0,1; each rsp_valid targets the granted requester.
- Requester 1 sends op 11 -> rsp_valid=10, rsp_err=1, rsp_data=0 one cycle after handshake; alu_op_select stays 00.
- Reset asserted at cycle 8 of a mult -> no rsp_valid; the next cycle shows all ALU outputs zero and state IDLE; a new request then completes normally.
